// File: rtl/fc_layer_engine.sv
// fc_layer_engine: one fully-connected layer (y = W*x + b) computed neuron by neuron over a single-port memory.
// Define FC_RELU_EN to clamp each neuron result at zero before write-back and argmax.
module fc_layer_engine #(
    parameter int FRAC_BITS = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  num_inputs,
    input  logic [7:0]  num_outputs,
    input  logic [15:0] act_base,
    input  logic [15:0] wt_base,
    input  logic [15:0] bias_base,
    input  logic [15:0] out_base,
    output logic        rd_en,
    output logic [15:0] rd_addr,
    input  logic [15:0] rd_data,
    output logic        wr_en,
    output logic [15:0] wr_addr,
    output logic [15:0] wr_data,
    output logic        busy,
    output logic        done,
    output logic        cfg_err,
    output logic [7:0]  max_index
);

    typedef enum logic [2:0] {
        IDLE, BIAS_RD, BIAS_CAP, ACT_RD, WT_RD, MAC, WRITE, FIN
    } state_t;

    state_t             state_q;
    logic [7:0]         n_q, m_q, i_q, j_q;
    logic [15:0]        act_base_q, wt_base_q, bias_base_q, out_base_q;
    logic [15:0]        wt_row_q;      // j*N modulo 2^16, advanced once per neuron
    logic signed [15:0] act_q;
    logic signed [39:0] acc_q;
    logic signed [15:0] max_val_q;
    logic [7:0]         max_idx_q;

    logic               rd_en_q, wr_en_q, busy_q, done_q, cfg_err_q;
    logic [15:0]        rd_addr_q, wr_addr_q, wr_data_q;
    logic [7:0]         max_index_q;

    logic signed [31:0] prod_d;
    logic signed [39:0] acc_d, bias_acc_d, shifted_d;
    logic signed [15:0] result_d, max_val_d;
    logic [7:0]         max_idx_d;
    logic               new_max_d, i_last_d, j_last_d;

    always_comb begin
        // NOTE: every branch of result_d is covered below; a missing else here would infer a latch.
        prod_d     = $signed({{16{act_q[15]}}, act_q}) * $signed({{16{rd_data[15]}}, rd_data});
        acc_d      = acc_q + $signed({{8{prod_d[31]}}, prod_d});
        bias_acc_d = $signed({{24{rd_data[15]}}, rd_data}) <<< FRAC_BITS;
        shifted_d  = acc_d >>> FRAC_BITS;
        if (shifted_d > 40'sd32767) begin
            result_d = 16'sh7FFF;
        end else if (shifted_d < -40'sd32768) begin
            result_d = 16'sh8000;
        end else begin
            result_d = shifted_d[15:0];
        end
`ifdef FC_RELU_EN
        if (result_d < 16'sd0) begin
            result_d = 16'sd0;
        end
`endif
        // Running argmax evaluated on the value being written; ties keep the earlier neuron.
        new_max_d = (j_q == 8'd0) || ($signed(wr_data_q) > max_val_q);
        max_val_d = new_max_d ? $signed(wr_data_q) : max_val_q;
        max_idx_d = new_max_d ? j_q : max_idx_q;
        i_last_d  = (i_q == n_q - 8'd1);
        j_last_d  = (j_q == m_q - 8'd1);
    end

    // NOTE: all state updates use non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            n_q         <= '0;
            m_q         <= '0;
            i_q         <= '0;
            j_q         <= '0;
            act_base_q  <= '0;
            wt_base_q   <= '0;
            bias_base_q <= '0;
            out_base_q  <= '0;
            wt_row_q    <= '0;
            act_q       <= '0;
            acc_q       <= '0;
            max_val_q   <= '0;
            max_idx_q   <= '0;
            rd_en_q     <= 1'b0;
            rd_addr_q   <= '0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            cfg_err_q   <= 1'b0;
            max_index_q <= '0;
        end else begin
            done_q    <= 1'b0;
            cfg_err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        busy_q <= 1'b1;
                        if (num_inputs == 8'd0 || num_outputs == 8'd0) begin
                            done_q    <= 1'b1;
                            cfg_err_q <= 1'b1;
                            state_q   <= FIN;
                        end else begin
                            n_q         <= num_inputs;
                            m_q         <= num_outputs;
                            act_base_q  <= act_base;
                            wt_base_q   <= wt_base;
                            bias_base_q <= bias_base;
                            out_base_q  <= out_base;
                            i_q         <= '0;
                            j_q         <= '0;
                            wt_row_q    <= '0;
                            rd_en_q     <= 1'b1;
                            rd_addr_q   <= bias_base;
                            state_q     <= BIAS_RD;
                        end
                    end
                end
                BIAS_RD: begin
                    rd_en_q <= 1'b0;
                    state_q <= BIAS_CAP;
                end
                BIAS_CAP: begin
                    acc_q     <= bias_acc_d;
                    rd_en_q   <= 1'b1;
                    rd_addr_q <= act_base_q + {8'd0, i_q};
                    state_q   <= ACT_RD;
                end
                ACT_RD: begin
                    rd_addr_q <= wt_base_q + wt_row_q + {8'd0, i_q};
                    state_q   <= WT_RD;
                end
                WT_RD: begin
                    act_q   <= rd_data;
                    rd_en_q <= 1'b0;
                    state_q <= MAC;
                end
                MAC: begin
                    acc_q <= acc_d;
                    if (i_last_d) begin
                        wr_en_q   <= 1'b1;
                        wr_addr_q <= out_base_q + {8'd0, j_q};
                        wr_data_q <= result_d;
                        state_q   <= WRITE;
                    end else begin
                        i_q       <= i_q + 8'd1;
                        rd_en_q   <= 1'b1;
                        rd_addr_q <= act_base_q + {8'd0, i_q + 8'd1};
                        state_q   <= ACT_RD;
                    end
                end
                WRITE: begin
                    wr_en_q   <= 1'b0;
                    max_val_q <= max_val_d;
                    max_idx_q <= max_idx_d;
                    if (j_last_d) begin
                        done_q      <= 1'b1;
                        max_index_q <= max_idx_d;
                        state_q     <= FIN;
                    end else begin
                        j_q       <= j_q + 8'd1;
                        i_q       <= '0;
                        wt_row_q  <= wt_row_q + {8'd0, n_q};
                        rd_en_q   <= 1'b1;
                        rd_addr_q <= bias_base_q + {8'd0, j_q + 8'd1};
                        state_q   <= BIAS_RD;
                    end
                end
                FIN: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rd_en     = rd_en_q;
    assign rd_addr   = rd_addr_q;
    assign wr_en     = wr_en_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign cfg_err   = cfg_err_q;
    assign max_index = max_index_q;

endmodule

// File: tb/tb_fc_layer_engine.sv
// Bench for fc_layer_engine: memory responder, arithmetic reference model with write scoreboard,
// and directed runs with hand-computed expectations.
`timescale 1ns/1ps
module tb_fc_layer_engine;

    localparam int FRAC = 8;

    logic        clk = 1'b0;
    logic        reset, start;
    logic [7:0]  num_inputs, num_outputs;
    logic [15:0] act_base, wt_base, bias_base, out_base;
    logic        rd_en, wr_en, busy, done, cfg_err;
    logic [15:0] rd_addr, rd_data, wr_addr, wr_data;
    logic [7:0]  max_index;

    fc_layer_engine #(.FRAC_BITS(FRAC)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .num_inputs (num_inputs),
        .num_outputs(num_outputs),
        .act_base   (act_base),
        .wt_base    (wt_base),
        .bias_base  (bias_base),
        .out_base   (out_base),
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .busy       (busy),
        .done       (done),
        .cfg_err    (cfg_err),
        .max_index  (max_index)
    );

    always #5 clk = ~clk;

    // Read-only data memory: data appears the cycle after the strobe.
    logic [15:0] mem [0:65535];
    always @(posedge clk) begin
        if (rd_en) rd_data <= mem[rd_addr];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          total = 0, bad = 0;
    logic [31:0] exp_wr [$];
    logic [31:0] exp_e;
    int          exp_lat = 0, exp_reads = 0, exp_writes = 0;
    logic        exp_cfg = 1'b0;
    logic [7:0]  exp_max = 8'd0;
    int          start_cyc = 0, rd_cnt = 0, wr_cnt = 0, done_cnt = 0, last_lat = 0;
    logic [15:0] last_wr_data = 16'd0, last_wr_addr = 16'd0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Layer computed straight from the arithmetic definition using 64-bit integers.
    function automatic void model_run(input int n, input int m, input logic [15:0] ab,
                                      input logic [15:0] wb, input logic [15:0] bb,
                                      input logic [15:0] ob);
        longint acc, res, best;
        int     bi;
        exp_wr.delete();
        exp_cfg = (n == 0 || m == 0);
        if (exp_cfg) begin
            exp_lat = 0; exp_reads = 0; exp_writes = 0;
            return;
        end
        best = 0; bi = 0;
        for (int j = 0; j < m; j++) begin
            acc = longint'($signed(mem[16'(bb + 16'(j))])) * (64'sd1 <<< FRAC);
            for (int i = 0; i < n; i++)
                acc += longint'($signed(mem[16'(ab + 16'(i))]))
                     * longint'($signed(mem[16'(wb + 16'(j * n + i))]));
            res = acc >>> FRAC;
            if (res > 32767)  res = 32767;
            if (res < -32768) res = -32768;
`ifdef FC_RELU_EN
            if (res < 0) res = 0;
`endif
            if (j == 0 || res > best) begin
                best = res;
                bi   = j;
            end
            exp_wr.push_back({16'(ob + 16'(j)), 16'(res)});
        end
        exp_lat    = m * (3 * n + 3);
        exp_reads  = m * (2 * n + 1);
        exp_writes = m;
        exp_max    = 8'(bi);
    endfunction

    // Single compare process: checks every cycle once out of reset.
    always @(negedge clk) begin
        if (reset === 1'b0) begin
            check("rd_wr_overlap", 32'(rd_en & wr_en), 32'd0);
            if (!busy) check("idle_quiet", 32'({rd_en, wr_en}), 32'd0);
            if (rd_en) rd_cnt++;
            if (wr_en) begin
                wr_cnt++;
                last_wr_data = wr_data;
                last_wr_addr = wr_addr;
                if (exp_wr.size() == 0) begin
                    check("unexpected_write", 32'(wr_cnt), 32'(exp_writes));
                end else begin
                    exp_e = exp_wr.pop_front();
                    check("wr_addr", 32'(wr_addr), 32'(exp_e[31:16]));
                    check("wr_data", 32'(wr_data), 32'(exp_e[15:0]));
                end
            end
            if (done) begin
                done_cnt++;
                last_lat = cyc - start_cyc;
                check("done_latency", 32'(last_lat), 32'(exp_lat));
                check("cfg_err", 32'(cfg_err), 32'(exp_cfg));
                check("read_count", 32'(rd_cnt), 32'(exp_reads));
                check("write_count", 32'(wr_cnt), 32'(exp_writes));
                check("pending_writes", 32'(exp_wr.size()), 32'd0);
            end else begin
                check("cfg_err_without_done", 32'(cfg_err), 32'd0);
            end
        end
    end

    task automatic launch(input int n, input int m, input logic [15:0] ab, input logic [15:0] wb,
                          input logic [15:0] bb, input logic [15:0] ob);
        model_run(n, m, ab, wb, bb, ob);
        rd_cnt = 0;
        wr_cnt = 0;
        @(negedge clk);
        num_inputs  = 8'(n);
        num_outputs = 8'(m);
        act_base    = ab;
        wt_base     = wb;
        bias_base   = bb;
        out_base    = ob;
        start       = 1'b1;
        start_cyc   = cyc + 1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int c0 = done_cnt;
        int k  = 0;
        while (done_cnt == c0 && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (done_cnt == c0) check("done_timeout", 32'(done_cnt - c0), 32'd1);
        @(negedge clk);
        check("busy_after_done", 32'(busy), 32'd0);
    endtask

    task automatic fill_small(input logic [15:0] base, input int count);
        for (int k = 0; k < count; k++)
            mem[16'(base + 16'(k))] = 16'(int'($urandom_range(0, 1023)) - 512);
    endtask

    task automatic fill_full(input logic [15:0] base, input int count);
        for (int k = 0; k < count; k++)
            mem[16'(base + 16'(k))] = 16'($urandom);
    endtask

    initial begin : watchdog
        #3_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        for (int a = 0; a < 65536; a++) mem[a] = 16'd0;
        reset = 1'b1; start = 1'b0;
        num_inputs = 8'd0; num_outputs = 8'd0;
        act_base = 16'd0; wt_base = 16'd0; bias_base = 16'd0; out_base = 16'd0;
        repeat (3) @(negedge clk);
        check("reset_strobes", 32'({rd_en, wr_en, busy, done, cfg_err}), 32'd0);
        check("reset_rd_addr", 32'(rd_addr), 32'd0);
        check("reset_wr_addr", 32'(wr_addr), 32'd0);
        check("reset_wr_data", 32'(wr_data), 32'd0);
        check("reset_max_index", 32'(max_index), 32'd0);

        // Reset wins over a simultaneous start.
        num_inputs = 8'd2; num_outputs = 8'd1; start = 1'b1;
        @(negedge clk);
        check("reset_over_start", 32'({busy, rd_en}), 32'd0);
        start = 1'b0; reset = 1'b0;
        repeat (2) @(negedge clk);
        check("no_run_after_reset", 32'(busy), 32'd0);

        // Small hand-checked layer: (0x100<<8 + 0x200*0x100 + 0x100*0x300) >> 8 = 0x600.
        mem[16'h0300] = 16'h0100;
        mem[16'h0100] = 16'h0200; mem[16'h0101] = 16'h0100;
        mem[16'h0200] = 16'h0100; mem[16'h0201] = 16'h0300;
        launch(2, 1, 16'h0100, 16'h0200, 16'h0300, 16'h0400);
        wait_done(100);
        check("basic_wr_data", 32'(last_wr_data), 32'h0600);
        check("basic_wr_addr", 32'(last_wr_addr), 32'h0400);
        check("basic_latency", 32'(last_lat), 32'd9);
        check("basic_max_index", 32'(max_index), 32'd0);

        // Positive and negative saturation.
        mem[16'h0500] = 16'h7FFF; mem[16'h0510] = 16'h7FFF; mem[16'h0520] = 16'h7FFF;
        launch(1, 1, 16'h0500, 16'h0510, 16'h0520, 16'h0530);
        wait_done(100);
        check("sat_pos", 32'(last_wr_data), 32'h7FFF);
        mem[16'h0510] = 16'h8000; mem[16'h0520] = 16'h8000;
        launch(1, 1, 16'h0500, 16'h0510, 16'h0520, 16'h0530);
        wait_done(100);
`ifdef FC_RELU_EN
        check("sat_neg", 32'(last_wr_data), 32'h0000);
`else
        check("sat_neg", 32'(last_wr_data), 32'h8000);
`endif

        // Results {5,9,9}: tie keeps the lower index; a start and config change while busy are ignored.
        mem[16'h0600] = 16'h0000;
        for (int k = 0; k < 3; k++) mem[16'h0610 + 16'(k)] = 16'h1234;
        mem[16'h0620] = 16'd5; mem[16'h0621] = 16'd9; mem[16'h0622] = 16'd9;
        launch(1, 3, 16'h0600, 16'h0610, 16'h0620, 16'h0630);
        repeat (3) @(negedge clk);
        num_inputs = 8'd5; num_outputs = 8'd7;
        act_base = 16'h0A00; wt_base = 16'h0B00; bias_base = 16'h0C00; out_base = 16'h0D00;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(100);
        check("tie_max_index", 32'(max_index), 32'd1);
        check("tie_last_data", 32'(last_wr_data), 32'd9);

        // Zero-size configurations: immediate cfg_err + done, argmax untouched.
        launch(0, 3, 16'h0600, 16'h0610, 16'h0620, 16'h0630);
        wait_done(20);
        check("cfg_n0_max_index", 32'(max_index), 32'd1);
        launch(4, 0, 16'h0600, 16'h0610, 16'h0620, 16'h0630);
        wait_done(20);
        check("cfg_m0_max_index", 32'(max_index), 32'd1);

        // 16-bit address wrap on weights and outputs.
        fill_full(16'h0800, 3); fill_full(16'h0810, 2); fill_full(16'hFFFC, 6);
        launch(3, 2, 16'h0800, 16'hFFFC, 16'h0810, 16'hFFFF);
        wait_done(100);

        // Reset during MAC of neuron 3 of 10 (N=4: neuron j's MAC is entered 15*j+4 edges after start).
        fill_small(16'h0900, 4); fill_small(16'h0A00, 40); fill_full(16'h0B00, 10);
        launch(4, 10, 16'h0900, 16'h0A00, 16'h0B00, 16'h0C00);
        d0 = done_cnt;
        while (cyc < start_cyc + 49) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("abort_idle", 32'({busy, rd_en, wr_en}), 32'd0);
        check("abort_writes", 32'(wr_cnt), 32'd3);
        check("abort_max_index", 32'(max_index), 32'd0);
        reset = 1'b0;
        exp_wr.delete();
        exp_writes = 3;
        repeat (60) @(negedge clk);
        check("abort_no_more_writes", 32'(wr_cnt), 32'd3);
        check("abort_no_done", 32'(done_cnt - d0), 32'd0);
        launch(4, 10, 16'h0900, 16'h0A00, 16'h0B00, 16'h0C00);
        wait_done(400);
        check("rerun_max_index", 32'(max_index), 32'(exp_max));

        // Full-size layer with random data.
        fill_small(16'h1000, 120); fill_small(16'h2000, 120 * 84); fill_full(16'h6000, 84);
        launch(120, 84, 16'h1000, 16'h2000, 16'h6000, 16'h7000);
        wait_done(40000);
        check("big_latency", 32'(last_lat), 32'd30492);
        check("big_writes", 32'(wr_cnt), 32'd84);
        check("big_max_index", 32'(max_index), 32'(exp_max));

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fc_layer_engine.md
FC_LAYER_ENGINE -- requirements
Module: fc_layer_engine

Interface
REQ-001 Parameter FRAC_BITS, default 8, number of fractional bits in the signed 16-bit fixed-point format.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  reset, synchronous, active-high.
REQ-004 start  input  1  request to run one fully-connected layer; sampled only in IDLE.
REQ-005 num_inputs  input  8  N, activations per neuron; sampled with start.
REQ-006 num_outputs  input  8  M, neurons; sampled with start.
REQ-007 act_base, wt_base, bias_base, out_base  input  16 each  memory base addresses; sampled with start.
REQ-008 rd_en  output  1  memory read strobe.
REQ-009 rd_addr  output  16  read address.
REQ-010 rd_data  input  16  read data, valid exactly one cycle after rd_en.
REQ-011 wr_en  output  1  memory write strobe.
REQ-012 wr_addr  output  16  write address.
REQ-013 wr_data  output  16  signed neuron result.
REQ-014 busy  output  1  high in every state except IDLE.
REQ-015 done  output  1  one-cycle completion pulse.
REQ-016 cfg_err  output  1  one-cycle pulse when N=0 or M=0.
REQ-017 max_index  output  8  index of largest neuron result of the last completed run.

Function
REQ-018 The FSM SHALL have states IDLE, BIAS_RD, BIAS_CAP, ACT_RD, WT_RD, MAC, WRITE, FIN.
REQ-019 IDLE with start=1 and N,M nonzero SHALL latch the configuration, clear neuron index j and input index i, and go to BIAS_RD.
REQ-020 IDLE with start=1 and N=0 or M=0 SHALL go to FIN with cfg_err asserted in FIN, issuing no reads or writes.
REQ-021 BIAS_RD: rd_en=1, rd_addr=bias_base+j; next BIAS_CAP.
REQ-022 BIAS_CAP: acc = sign-extended rd_data shifted left FRAC_BITS; next ACT_RD.
REQ-023 ACT_RD: rd_en=1, rd_addr=act_base+i; next WT_RD.
REQ-024 WT_RD: capture rd_data as activation; rd_en=1, rd_addr=wt_base+j*N+i; next MAC.
REQ-025 MAC: acc += activation*rd_data (signed 16x16 to 32-bit product, 40-bit signed accumulator); if i<N-1 then i++ and ACT_RD, else WRITE.
REQ-026 All address arithmetic SHALL be 16-bit modulo 2^16.
REQ-027 WRITE: result = acc arithmetic-shifted right FRAC_BITS, saturated to [-32768, 32767]; wr_en=1, wr_addr=out_base+j, wr_data=result.
REQ-028 WRITE SHALL update the running maximum; j=0 always loads it; ties keep the lower index.
REQ-029 WRITE: if j<M-1 then j++, i=0, go BIAS_RD; else go FIN.
REQ-030 FIN: done=1 for one cycle, max_index updated from the running maximum (unchanged on cfg_err), then IDLE.
REQ-031 Cycle count from the edge sampling start to the edge entering FIN SHALL be M*(3N+3).
REQ-032 start while busy SHALL be ignored; configuration inputs SHALL be ignored while busy.
REQ-033 rd_en and wr_en SHALL never be high in the same cycle; rd_en/wr_en SHALL be 0 in IDLE, BIAS_CAP, FIN.
REQ-034 start in the FIN cycle SHALL be ignored; a new run starts from IDLE on a later cycle.

Reset
REQ-035 reset SHALL force state IDLE, rd_en=0, wr_en=0, rd_addr=0, wr_addr=0, wr_data=0, busy=0, done=0, cfg_err=0, max_index=0, acc=0, i=0, j=0.
REQ-036 reset mid-run SHALL abort with no further reads or writes, and no done pulse; reset takes priority over start.

Configuration
REQ-037 With macro FC_RELU_EN defined, WRITE SHALL output max(result,0) and the argmax SHALL use the clamped value; without it the saturated signed result is output unchanged.

Verification
REQ-038 N=2, M=1, bias=0x0100, act={0x0200,0x0100}, wt={0x0100,0x0300}, FRAC_BITS=8 -> one write of 0x0600 at out_base, done 9 cycles after start.
REQ-039 N=120, M=84, random data -> 84 writes matching a bit-exact reference model, done after 84*363 cycles, max_index matches model.
REQ-040 N=1, M=1, act=0x7FFF, wt=0x7FFF, bias=0x7FFF -> wr_data=0x7FFF (saturation); negative equivalent -> 0x8000 without FC_RELU_EN, 0x0000 with it.
REQ-041 start with N=0 -> cfg_err and done pulse in same cycle, no rd_en/wr_en, max_index unchanged.
REQ-042 reset asserted during MAC of neuron 3 of 10 -> IDLE next cycle, no further writes, no done; fresh start then completes normally.
REQ-043 M=3 results {5,9,9} -> max_index=1; start pulsed while busy -> no effect on count or addresses.
